// File: rtl/io_bus_responder.sv
// io_bus_responder: memory-mapped I/O target on the multicycle CPU data bus.
// Latency: request seen in IDLE -> one-cycle ready pulse WAIT_CYCLES+2 clk_cpu edges later.
// Backpressure: nothing is queued; the CPU holds MemRead/MemWrite until ready,
//   and HOLD waits for both strobes to drop so a held request is served once.
//
// Ports:
//   clk_cpu, rst_cpu     CPU clock; asynchronous active-high reset.
//   MemRead, MemWrite    CPU access strobes (level, held for the whole beat).
//   addr, wdata          Byte address and store data from the CPU.
//   rdata                Registered read data, valid while ready is high and
//                        held until the next read completes.
//   sel                  Combinational window hit qualified by a strobe; the
//                        top level uses it to mux rdata into the load path.
//   ready                One-cycle completion pulse.
//   sw_in, btn_in        Board switches and debounced buttons.
//   led_out, disp_out    LED and display registers.
//   timer_irq            Sticky timer-match flag (STATUS bit0).
//
// Register map (offset = addr[7:0], addr[1:0] ignored):
//   0x00 SW (RO)   0x04 BTN (RO)   0x08 LED (RW, [7:0])   0x0C DISP (RW)
//   0x10 TIMER (RO, any write clears)   0x14 CMP (RW)
//   0x18 STATUS (bit0 timer match, bit1 bus error; sticky, write-1-to-clear)
//
// Build option: define IO_TIMER_EN to include TIMER, CMP, STATUS bit0 and
//   timer_irq. Without it those offsets read 0 and timer_irq is tied low.

module io_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_cpu,
  input  logic        rst_cpu,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        ready,
  input  logic [7:0]  sw_in,
  input  logic [3:0]  btn_in,
  output logic [7:0]  led_out,
  output logic [31:0] disp_out,
  output logic        timer_irq
);

  // Word offsets (addr[7:2]).
  localparam logic [5:0] OFF_SW     = 6'h00;
  localparam logic [5:0] OFF_BTN    = 6'h01;
  localparam logic [5:0] OFF_LED    = 6'h02;
  localparam logic [5:0] OFF_DISP   = 6'h03;
  localparam logic [5:0] OFF_TIMER  = 6'h04;
  localparam logic [5:0] OFF_CMP    = 6'h05;
  localparam logic [5:0] OFF_STATUS = 6'h06;

  // Wait counter is 4 bits wide; WAIT_CYCLES is meant to stay within 0..15.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } state_t;

  // Request captured at acceptance; the bus may change after that point
  // without affecting the access in flight.
  typedef struct packed {
    logic [5:0]  off;
    logic        wr;    // write (also set when both strobes are high)
    logic        err;   // both strobes high at acceptance
    logic [31:0] dat;
  } req_t;

  state_t      state_q;
  state_t      state_d;
  req_t        req_q;
  logic [3:0]  wcnt_q;

  logic        hit;
  logic        accept;     // IDLE -> WAIT this cycle
  logic        resp_fire;  // WAIT -> RESP this cycle; commit happens on this edge
  logic        wr_fire;
  logic        rd_fire;

  logic [31:0] rd_mux;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic [7:0]  led_q;
  logic [31:0] disp_q;
  logic        stat_match_q;
  logic        stat_err_q;
  logic [31:0] timer_rd;
  logic [31:0] cmp_rd;

  logic        unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, addr[1:0]};

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign hit = (addr[31:8] == BASE_ADDR[31:8]);
  assign sel = hit & (MemRead | MemWrite);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    resp_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          resp_fire = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!MemRead && !MemWrite) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The RESP actions (write commit, rdata load, ready) are registered on the
  // edge that enters RESP, so during the RESP cycle ready, rdata and the
  // written register all show the completed access together.
  assign wr_fire = resp_fire & req_q.wr;
  assign rd_fire = resp_fire & ~req_q.wr;

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      wcnt_q <= 4'd0;
    end else if (accept) begin
      wcnt_q <= WAIT_INIT;
    end else if (state_q == ST_WAIT && wcnt_q != 4'd0) begin
      wcnt_q <= wcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.off <= addr[7:2];
      req_q.wr  <= MemWrite;
      req_q.err <= MemRead & MemWrite;
      req_q.dat <= wdata;
    end
  end

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= resp_fire;
    end
  end

  assign ready = ready_q;

  // ---------------------------------------------------------------------------
  // Read path: sampled from current register values at the commit edge
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = 32'd0;
    case (req_q.off)
      OFF_SW:     rd_mux = {24'd0, sw_in};
      OFF_BTN:    rd_mux = {28'd0, btn_in};
      OFF_LED:    rd_mux = {24'd0, led_q};
      OFF_DISP:   rd_mux = disp_q;
      OFF_TIMER:  rd_mux = timer_rd;
      OFF_CMP:    rd_mux = cmp_rd;
      OFF_STATUS: rd_mux = {30'd0, stat_err_q, stat_match_q};
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      rdata_q <= 32'd0;
    end else if (rd_fire) begin
      rdata_q <= rd_mux;
    end
  end

  assign rdata = rdata_q;

  // ---------------------------------------------------------------------------
  // Writable registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      led_q  <= 8'd0;
      disp_q <= 32'd0;
    end else if (wr_fire) begin
      if (req_q.off == OFF_LED) begin
        led_q <= req_q.dat[7:0];
      end
      if (req_q.off == OFF_DISP) begin
        disp_q <= req_q.dat;
      end
    end
  end

  assign led_out  = led_q;
  assign disp_out = disp_q;

  // Bus-error flag: a new error has priority over a simultaneous clear.
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      stat_err_q <= 1'b0;
    end else if (resp_fire && req_q.err) begin
      stat_err_q <= 1'b1;
    end else if (wr_fire && req_q.off == OFF_STATUS && req_q.dat[1]) begin
      stat_err_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare timer
  // ---------------------------------------------------------------------------
`ifdef IO_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] cmp_q;
  logic        match;

  assign match = (timer_q == cmp_q);

  // A TIMER write overrides the free-running increment; wrap is natural.
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      timer_q <= 32'd0;
    end else if (wr_fire && req_q.off == OFF_TIMER) begin
      timer_q <= 32'd0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      cmp_q <= 32'hFFFF_FFFF;
    end else if (wr_fire && req_q.off == OFF_CMP) begin
      cmp_q <= req_q.dat;
    end
  end

  // Match flag: a match on the same edge as a W1C keeps the flag set.
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      stat_match_q <= 1'b0;
    end else if (match) begin
      stat_match_q <= 1'b1;
    end else if (wr_fire && req_q.off == OFF_STATUS && req_q.dat[0]) begin
      stat_match_q <= 1'b0;
    end
  end

  // timer_q is read before this edge's increment, i.e. the pre-increment value.
  assign timer_rd  = timer_q;
  assign cmp_rd    = cmp_q;
  assign timer_irq = stat_match_q;
`else
  assign stat_match_q = 1'b0;
  assign timer_rd     = 32'd0;
  assign cmp_rd       = 32'd0;
  assign timer_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder: directed bench for io_bus_responder with a read-data
// scoreboard (expected rdata queued at drive time, popped at ready).
// Inputs change on the falling clock edge; outputs are sampled there too.

module tb_io_bus_responder;

  localparam int          WC       = 2;
  localparam logic [31:0] A_SW     = 32'hF000_0000;
  localparam logic [31:0] A_BTN    = 32'hF000_0007;  // low bits ignored -> BTN
  localparam logic [31:0] A_LED    = 32'hF000_0008;
  localparam logic [31:0] A_DISP   = 32'hF000_000C;
  localparam logic [31:0] A_TIMER  = 32'hF000_0010;
  localparam logic [31:0] A_CMP    = 32'hF000_0014;
  localparam logic [31:0] A_STATUS = 32'hF000_0018;
  localparam logic [31:0] A_HOLE   = 32'hF000_0040;

  logic        clk_cpu;
  logic        rst_cpu;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;
  logic        ready;
  logic [7:0]  sw_in;
  logic [3:0]  btn_in;
  logic [7:0]  led_out;
  logic [31:0] disp_out;
  logic        timer_irq;

  int          tests;
  int          fails;
  logic [31:0] exp_q[$];

  io_bus_responder #(
    .BASE_ADDR  (32'hF000_0000),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk_cpu  (clk_cpu),
    .rst_cpu  (rst_cpu),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .sel      (sel),
    .ready    (ready),
    .sw_in    (sw_in),
    .btn_in   (btn_in),
    .led_out  (led_out),
    .disp_out (disp_out),
    .timer_irq(timer_irq)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge and wait (bounded) for ready. Returns at
  // the falling edge where ready is seen, request still held.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    int          lat;
    logic [31:0] exp;
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    #1;
    check1({tag, " sel"}, sel, 1'b1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_cpu);
      if (ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    check32({tag, " latency"}, 32'(lat), 32'(WC + 2));
    if (rd && !wr) begin
      if (exp_q.size() == 0) begin
        check32({tag, " scoreboard empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        exp = exp_q.pop_front();
        if (lat != 0) check32({tag, " rdata"}, rdata, exp);
      end
    end
  endtask

  // Keep the request held a few cycles (must not be served again), then drop it.
  task automatic release_req(input string tag);
    int extra;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_cpu);
      if (ready !== 1'b0) extra++;
    end
    check32({tag, " no re-serve"}, 32'(extra), 32'd0);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk_cpu);
  endtask

  task automatic rd_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    do_req(tag, 1'b1, 1'b0, a, 32'h5555_AAAA);
    release_req(tag);
  endtask

  task automatic wr_word(input string tag, input logic [31:0] a, input logic [31:0] d);
    do_req(tag, 1'b0, 1'b1, a, d);
    release_req(tag);
  endtask

  initial begin
    int cnt;
    tests    = 0;
    fails    = 0;
    rst_cpu  = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = 32'd0;
    wdata    = 32'd0;
    sw_in    = 8'h00;
    btn_in   = 4'h0;

    // Reset state
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    check32("rst rdata", rdata, 32'd0);
    check1("rst ready", ready, 1'b0);
    check32("rst led", {24'd0, led_out}, 32'd0);
    check32("rst disp", disp_out, 32'd0);
    check1("rst irq", timer_irq, 1'b0);
    check1("rst sel", sel, 1'b0);
    rst_cpu = 1'b0;
    @(negedge clk_cpu);

    // SW read with held request, then a second read after the strobe drops
    sw_in = 8'hA5;
    rd_word("sw1", A_SW, 32'h0000_00A5);
    addr = A_SW;
    #1;
    check1("sel idle strobes", sel, 1'b0);
    @(negedge clk_cpu);
    sw_in = 8'h5A;
    rd_word("sw2", A_SW, 32'h0000_005A);

    // Out-of-window read: no sel, no ready, rdata unchanged
    MemRead = 1'b1;
    addr    = 32'h0000_0040;
    #1;
    check1("oow sel", sel, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_cpu);
      if (ready !== 1'b0) cnt++;
    end
    check32("oow ready count", 32'(cnt), 32'd0);
    check32("oow rdata", rdata, 32'h0000_005A);
    MemRead = 1'b0;
    @(negedge clk_cpu);

    // LED write and read-back; writes leave rdata alone
    do_req("led wr", 1'b0, 1'b1, A_LED, 32'h1234_56C3);
    check32("led at resp", {24'd0, led_out}, 32'h0000_00C3);
    check32("led wr rdata", rdata, 32'h0000_005A);
    release_req("led wr");
    rd_word("led rd", A_LED, 32'h0000_00C3);

    // Buttons, display, unmapped offset
    btn_in = 4'h9;
    rd_word("btn", A_BTN, 32'h0000_0009);
    wr_word("disp wr", A_DISP, 32'h0BAD_F00D);
    check32("disp out", disp_out, 32'h0BAD_F00D);
    rd_word("disp rd", A_DISP, 32'h0BAD_F00D);
    wr_word("hole wr", A_HOLE, 32'hFFFF_FFFF);
    rd_word("hole rd", A_HOLE, 32'd0);
    check32("hole no side effect", disp_out, 32'h0BAD_F00D);

    // Both strobes high: write wins, error flag set, rdata untouched
    sw_in = 8'hA5;
    rd_word("sw3", A_SW, 32'h0000_00A5);
    do_req("err wr", 1'b1, 1'b1, A_DISP, 32'hDEAD_BEEF);
    check32("err disp", disp_out, 32'hDEAD_BEEF);
    check32("err rdata", rdata, 32'h0000_00A5);
    release_req("err wr");
    rd_word("status err", A_STATUS, 32'h0000_0002);
    wr_word("w1c err", A_STATUS, 32'h0000_0002);
    rd_word("status clr", A_STATUS, 32'h0000_0000);

    // Reset during WAIT of a DISP write
    rd_word("led rd2", A_LED, 32'h0000_00C3);
    MemWrite = 1'b1;
    addr     = A_DISP;
    wdata    = 32'h1111_1111;
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    #2 rst_cpu = 1'b1;
    #1;
    check32("mid rst disp", disp_out, 32'd0);
    check32("mid rst rdata", rdata, 32'd0);
    check32("mid rst led", {24'd0, led_out}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_cpu);
      if (ready !== 1'b0) cnt++;
    end
    MemWrite = 1'b0;
    @(negedge clk_cpu);
    rst_cpu = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_cpu);
      if (ready !== 1'b0) cnt++;
    end
    check32("mid rst ready count", 32'(cnt), 32'd0);
    check32("mid rst no commit", disp_out, 32'd0);
    rd_word("disp after rst", A_DISP, 32'd0);

`ifdef IO_TIMER_EN
    // Match: CMP=10, clear TIMER at edge E (ready seen at t=0)
    wr_word("cmp10", A_CMP, 32'd10);
    do_req("tclr", 1'b0, 1'b1, A_TIMER, 32'hFFFF_FFFF);
    check1("irq before match", timer_irq, 1'b0);
    MemWrite = 1'b0;
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    // Read accepted at E+3, sampled at E+6 with the pre-increment value 5
    exp_q.push_back(32'd5);
    do_req("tread", 1'b1, 1'b0, A_TIMER, 32'd0);
    MemRead = 1'b0;
    for (int t = 7; t <= 12; t++) begin
      @(negedge clk_cpu);
      check1($sformatf("irq t=%0d", t), timer_irq, (t >= 11));
    end
    rd_word("status match", A_STATUS, 32'h0000_0001);
    do_req("w1c match", 1'b0, 1'b1, A_STATUS, 32'h0000_0001);
    check1("irq after w1c", timer_irq, 1'b0);
    release_req("w1c match");
    rd_word("status w1c", A_STATUS, 32'h0000_0000);

    // W1C landing on the match edge: set wins
    wr_word("cmp5", A_CMP, 32'd5);
    do_req("tclr2", 1'b0, 1'b1, A_TIMER, 32'd0);
    MemWrite = 1'b0;
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    do_req("w1c race", 1'b0, 1'b1, A_STATUS, 32'h0000_0001);
    check1("irq race", timer_irq, 1'b1);
    release_req("w1c race");
    rd_word("status race", A_STATUS, 32'h0000_0001);
    rd_word("cmp rd", A_CMP, 32'd5);
    wr_word("w1c final", A_STATUS, 32'h0000_0001);
    check1("irq final", timer_irq, 1'b0);
`else
    // Timer absent: TIMER/CMP read 0, writes ignored, irq stays low
    rd_word("timer absent", A_TIMER, 32'd0);
    wr_word("cmp write", A_CMP, 32'h0000_0003);
    rd_word("cmp absent", A_CMP, 32'd0);
    wr_word("timer write", A_TIMER, 32'd0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_cpu);
      if (timer_irq !== 1'b0) cnt++;
    end
    check32("irq absent count", 32'(cnt), 32'd0);
    rd_word("status absent", A_STATUS, 32'd0);
`endif

    check32("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Memory-mapped I/O responder on the multicycle CPU data bus. The CPU is the bus initiator; this block is the target.
- Decodes CPU load/store accesses whose address is in the I/O window and answers them after a programmable wait.
- Exposes board switches and buttons, an LED register, a 32-bit display register and a compare timer.
- Sits beside the data memory. The top level muxes rdata into the load path when sel=1.

Parameters:
- BASE_ADDR, 32'hF000_0000: I/O window base. A hit is addr[31:8]==BASE_ADDR[31:8].
- WAIT_CYCLES, 2: wait cycles between request acceptance and ready. Legal range 0..15.

Ports:
- clk_cpu  in  1  CPU clock.
- rst_cpu  in  1  Asynchronous, active-high reset.
- MemRead  in  1  CPU read request, level, held for the whole beat.
- MemWrite  in  1  CPU write request, level.
- addr  in  32  Byte address (ALUOut).
- wdata  in  32  Store data (rt content).
- rdata  out  32  Read data, registered.
- sel  out  1  Combinational: addr in window and (MemRead|MemWrite).
- ready  out  1  One-cycle completion pulse.
- sw_in  in  8  Switches.
- btn_in  in  4  Debounced buttons.
- led_out  out  8  LED register.
- disp_out  out  32  Display register.
- timer_irq  out  1  Timer match interrupt.

Behaviour:
- Reset clears all state:
  - rdata=0, ready=0, led_out=0, disp_out=0, timer=0, cmp=32'hFFFF_FFFF, status=0, timer_irq=0.
  - FSM returns to IDLE, including reset asserted mid-transaction. No partial write is committed.
- Register map, offset = addr[7:0]. addr[1:0] is ignored (word access only).
  - 0x00 SW: RO, {24'b0, sw_in}.
  - 0x04 BTN: RO, {28'b0, btn_in}.
  - 0x08 LED: RW, bits [7:0]. Upper bits read 0.
  - 0x0C DISP: RW, 32 bits.
  - 0x10 TIMER: RO count. Any write clears it to 0.
  - 0x14 CMP: RW.
  - 0x18 STATUS: bit0 timer match (sticky), bit1 bus error (sticky). Write-1-to-clear.
  - Any other offset: reads return 0, writes are ignored, ready is still given.
- FSM states IDLE, WAIT, RESP, HOLD.
  - IDLE: on a hit, capture offset, wdata and direction, load wcnt=WAIT_CYCLES, go to WAIT. A non-hit stays in IDLE (no ready, sel=0).
  - WAIT: if wcnt==0 go to RESP, else decrement wcnt.
  - RESP: commit the write, or load rdata from the sampled register. ready=1 for this cycle only. Go to HOLD.
  - HOLD: stay until MemRead==0 and MemWrite==0, then go to IDLE. Prevents one held request from being served twice.
- Latency:
  - request seen in IDLE -> ready asserted WAIT_CYCLES+2 clk_cpu edges later.
  - WAIT_CYCLES=0 -> ready on the 2nd edge.
- rdata keeps its last value outside RESP. Writes never modify rdata.
- Register values used at RESP:
  - Read data is sampled in RESP from current register values.
  - The timer value returned is the pre-increment value of that cycle.
- MemRead and MemWrite both high at acceptance: treated as a write; status bit1 is set; rdata is unchanged.
- Timer:
  - Increments every clk_cpu, 32-bit wrap from FFFF_FFFF to 0.
  - When timer==cmp, status bit0 is set on the next edge.
  - A W1C of bit0 in the same cycle as a match: set wins.
  - A TIMER write in the same cycle as an increment: clear wins.
  - timer_irq = status bit0, registered.
- A request arriving while in WAIT, RESP or HOLD is not queued. The CPU holds the request until ready.

Optional Feature:
- Macro IO_TIMER_EN.
- When defined: TIMER, CMP and STATUS bit0 exist as described above.
- When undefined:
  - No timer or cmp flops.
  - Offsets 0x10 and 0x14 read 0 and ignore writes.
  - STATUS bit0 reads 0.
  - timer_irq is tied 0.
  - STATUS bit1 and all other behaviour are unchanged.

Test Plan:
- Read SW, WAIT_CYCLES=2: sw_in=8'hA5, MemRead=1, addr=F000_0000 held -> ready pulses exactly 4 edges after acceptance, rdata=0000_00A5. Second ready only after MemRead drops and rises again.
- Write/read LED: store 0x1234_56C3 to F000_0008 -> led_out=C3 at the RESP edge. Read back -> rdata=0000_00C3.
- Out-of-window: MemRead with addr=0000_0040 -> sel=0, ready never asserts, FSM stays IDLE, rdata unchanged.
- Timer: write CMP=10, write TIMER=0 -> status bit0 and timer_irq go high the edge after timer==10. W1C of STATUS=1 -> both clear. Simultaneous match and W1C -> stays set. Timer=FFFF_FFFF wraps to 0.
- Error and reset: MemRead=MemWrite=1 to DISP with wdata=DEAD_BEEF -> disp_out=DEAD_BEEF, STATUS reads 2. Assert rst_cpu during WAIT of a DISP write -> disp_out=0, ready never pulses, FSM in IDLE.
- Build without IO_TIMER_EN: read 0x10 -> 0. Write CMP then read 0x14 -> 0. timer_irq stays 0 over 100 cycles.
